// File: rtl/spi_flash_emu_pkg.sv
// spi_flash_emu_pkg
//   Shared definitions for the SPI NOR flash emulator: supported opcodes,
//   the transaction FSM state type and small byte-selection helpers.
package spi_flash_emu_pkg;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam logic [7:0] CMD_RDID      = 8'h9F;
  localparam logic [7:0] CMD_RDSR      = 8'h05;
  localparam logic [7:0] CMD_RPD       = 8'hAB;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_ID,
    ST_STATUS,
    ST_OTHER
  } state_t;

  // JEDEC ID is sent MSB byte first; anything past the third byte reads 00h.
  function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
    case (idx)
      2'd0:    return id[23:16];
      2'd1:    return id[15:8];
      2'd2:    return id[7:0];
      default: return 8'h00;
    endcase
  endfunction

  // Image words hold bytes little-endian: byte lane 0 is bits 7:0.
  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    case (lane)
      2'd0:    return word[7:0];
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      default: return word[31:24];
    endcase
  endfunction

endpackage

// File: rtl/spi_flash_emu_shifter.sv
// spi_flash_emu_shifter
//   SPI pin front end: 2-FF synchronisers, registered SCK rise/fall and CS-fall
//   events, MSB-first receive shifter with byte strobe, and the MISO shifter.
// Ports:
//   clk, rst               system clock, synchronous active-high reset
//   spi_clk/cs_n/mosi      raw SPI pins (mode 0, asynchronous to clk)
//   tx_load, tx_byte       next byte to transmit; held until the next SCK fall
//   spi_miso               transmit data (MSB of the out shift register)
//   cs_high                synchronised chip-select-inactive level
//   cs_fall_evt            one-cycle pulse on synchronised CS assertion
//   byte_stb, rx_byte      one-cycle pulse with each completed received byte
module spi_flash_emu_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  input  logic       tx_load,
  input  logic [7:0] tx_byte,
  output logic       spi_miso,
  output logic       cs_high,
  output logic       cs_fall_evt,
  output logic       byte_stb,
  output logic [7:0] rx_byte
);

  logic sck_s1, sck_s2, sck_d;
  logic cs_s1, cs_s2, cs_d;
  logic mosi_s1, mosi_s2, mosi_bit;
  logic rise_evt, fall_evt;
  logic [2:0] bit_cnt;
  logic [6:0] in_sr;
  logic [7:0] out_sr, pend_byte;
  logic       pend_valid;

  // Synchronisers and registered edge events (pin to event: 3 clk).
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_s1 <= 1'b0; sck_s2 <= 1'b0; sck_d <= 1'b0;
      cs_s1 <= 1'b1; cs_s2 <= 1'b1; cs_d <= 1'b1;
      mosi_s1 <= 1'b0; mosi_s2 <= 1'b0; mosi_bit <= 1'b0;
      rise_evt <= 1'b0; fall_evt <= 1'b0; cs_fall_evt <= 1'b0;
    end else begin
      sck_s1 <= spi_clk;  sck_s2 <= sck_s1;  sck_d <= sck_s2;
      cs_s1 <= spi_cs_n;  cs_s2 <= cs_s1;    cs_d <= cs_s2;
      mosi_s1 <= spi_mosi; mosi_s2 <= mosi_s1;
      // MOSI travels alongside the rise event so the sampled bit lines up.
      mosi_bit    <= mosi_s2;
      rise_evt    <= sck_s2 & ~sck_d;
      fall_evt    <= ~sck_s2 & sck_d;
      cs_fall_evt <= ~cs_s2 & cs_d;
    end
  end

  assign cs_high = cs_s2;

  // Receive side: a partial byte is dropped whenever CS goes inactive.
  always_ff @(posedge clk) begin
    if (rst || cs_s2) begin
      bit_cnt  <= 3'd0;
      in_sr    <= 7'd0;
      byte_stb <= 1'b0;
      rx_byte  <= 8'h00;
    end else begin
      byte_stb <= 1'b0;
      if (rise_evt) begin
        in_sr   <= {in_sr[5:0], mosi_bit};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_stb <= 1'b1;
          rx_byte  <= {in_sr, mosi_bit};
        end
      end
    end
  end

  // Transmit side: a loaded byte waits in pend_byte and becomes visible on the
  // next SCK fall, so bit 7 is presented for the following rise rather than
  // being shifted away by that fall.
  always_ff @(posedge clk) begin
    if (rst || cs_s2) begin
      out_sr     <= 8'h00;
      pend_byte  <= 8'h00;
      pend_valid <= 1'b0;
    end else if (fall_evt) begin
      pend_valid <= 1'b0;
      if (tx_load)         out_sr <= tx_byte;
      else if (pend_valid) out_sr <= pend_byte;
      else                 out_sr <= {out_sr[6:0], 1'b0};
    end else if (tx_load) begin
      pend_byte  <= tx_byte;
      pend_valid <= 1'b1;
    end
  end

  assign spi_miso = out_sr[7];

endmodule

// File: rtl/spi_flash_emu.sv
// spi_flash_emu
//   SPI NOR flash emulator answering 03h/0Bh/9Fh/05h (others read 00h) from a
//   host-loaded RAM image of 2^MEM_AW little-endian 32-bit words.
// Ports:
//   clk, rst                       system clock, synchronous active-high reset
//   spi_clk, spi_cs_n, spi_mosi    SPI inputs (mode 0, spi_clk <= clk/8)
//   spi_miso                       SPI data out
//   mem_wr_data/addr/ena           host image write port, one word per cycle
//   mon_cmd, mon_cmd_stb           last opcode and its update pulse
//   mon_addr, mon_addr_stb         last read address and its update pulse
module spi_flash_emu
  import spi_flash_emu_pkg::*;
#(
  parameter int          MEM_AW      = 10,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
  parameter int          DUMMY_BYTES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  input  logic [31:0]       mem_wr_data,
  input  logic [MEM_AW-1:0] mem_wr_addr,
  input  logic              mem_wr_ena,
  output logic [7:0]        mon_cmd,
  output logic              mon_cmd_stb,
  output logic [23:0]       mon_addr,
  output logic              mon_addr_stb
);

  localparam int   DCW       = (DUMMY_BYTES > 1) ? $clog2(DUMMY_BYTES) : 1;
  localparam int   DLAST     = (DUMMY_BYTES > 0) ? DUMMY_BYTES - 1 : 0;
  localparam logic HAS_DUMMY = (DUMMY_BYTES > 0);

  logic       cs_high, cs_fall_evt, byte_stb;
  logic [7:0] rx_byte;
  logic       tx_load;
  logic [7:0] tx_byte;

  state_t           state_reg;
  logic [23:0]      addr_reg;
  logic [1:0]       byte_cnt_reg;
  logic [1:0]       id_cnt_reg;
  logic [DCW-1:0]   dummy_cnt_reg;
  logic             dummy_flag_reg;

  logic [31:0] mem [0:(1<<MEM_AW)-1];
  logic [31:0] rd_word_reg;
  logic [1:0]  lane_reg;
  logic        ld_ram_reg, ld_const_reg;
  logic [7:0]  const_reg;

  logic [23:0]       full_addr;
  logic [MEM_AW+1:0] rd_addr;
  logic              ram_ld, const_ld;
  logic [7:0]        const_byte;

  spi_flash_emu_shifter u_shifter (
    .clk         (clk),
    .rst         (rst),
    .spi_clk     (spi_clk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .tx_load     (tx_load),
    .tx_byte     (tx_byte),
    .spi_miso    (spi_miso),
    .cs_high     (cs_high),
    .cs_fall_evt (cs_fall_evt),
    .byte_stb    (byte_stb),
    .rx_byte     (rx_byte)
  );

  // Decide on each byte_stb what the next transmitted byte is. While the last
  // address byte arrives, the read address is taken straight from the incoming
  // byte so the RAM read can start in the same cycle the FSM advances.
  always_comb begin
    full_addr  = {addr_reg[15:0], rx_byte};
    rd_addr    = (state_reg == ST_ADDR) ? full_addr[MEM_AW+1:0] : addr_reg[MEM_AW+1:0];
    ram_ld     = 1'b0;
    const_ld   = 1'b0;
    const_byte = 8'h00;
    if (byte_stb && !cs_high) begin
      case (state_reg)
        ST_CMD: begin
          if (rx_byte == CMD_RDID) begin
            const_ld   = 1'b1;
            const_byte = id_byte(JEDEC_ID, 2'd0);
          end else if (rx_byte != CMD_READ && rx_byte != CMD_FAST_READ) begin
            const_ld = 1'b1;
          end
        end
        ST_ADDR:  ram_ld = (byte_cnt_reg == 2'd2) && !(dummy_flag_reg && HAS_DUMMY);
        ST_DUMMY: ram_ld = (dummy_cnt_reg == DCW'(DLAST));
        ST_DATA:  ram_ld = 1'b1;
        ST_ID: begin
          const_ld   = 1'b1;
          const_byte = id_byte(JEDEC_ID, id_cnt_reg);
        end
        ST_STATUS, ST_OTHER: const_ld = 1'b1;
        default: ;
      endcase
    end
  end

  // Transaction FSM with address register and monitor outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      addr_reg       <= 24'h0;
      byte_cnt_reg   <= 2'd0;
      id_cnt_reg     <= 2'd0;
      dummy_cnt_reg  <= '0;
      dummy_flag_reg <= 1'b0;
      mon_cmd        <= 8'h00;
      mon_cmd_stb    <= 1'b0;
      mon_addr       <= 24'h0;
      mon_addr_stb   <= 1'b0;
    end else begin
      mon_cmd_stb  <= 1'b0;
      mon_addr_stb <= 1'b0;
      if (cs_high) begin
        state_reg <= ST_IDLE;
      end else begin
        case (state_reg)
          ST_IDLE: if (cs_fall_evt) begin
            state_reg      <= ST_CMD;
            byte_cnt_reg   <= 2'd0;
            id_cnt_reg     <= 2'd0;
            dummy_cnt_reg  <= '0;
            dummy_flag_reg <= 1'b0;
          end
          ST_CMD: if (byte_stb) begin
            mon_cmd     <= rx_byte;
            mon_cmd_stb <= 1'b1;
            case (rx_byte)
              CMD_READ:      state_reg <= ST_ADDR;
              CMD_FAST_READ: begin
                state_reg      <= ST_ADDR;
                dummy_flag_reg <= 1'b1;
              end
              CMD_RDID: begin
                state_reg  <= ST_ID;
                id_cnt_reg <= 2'd1;
              end
              CMD_RDSR:      state_reg <= ST_STATUS;
              default:       state_reg <= ST_OTHER;
            endcase
          end
          ST_ADDR: if (byte_stb) begin
            addr_reg     <= full_addr;
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (byte_cnt_reg == 2'd2) begin
              mon_addr     <= full_addr;
              mon_addr_stb <= 1'b1;
              if (dummy_flag_reg && HAS_DUMMY) begin
                state_reg <= ST_DUMMY;
              end else begin
                state_reg <= ST_DATA;
                addr_reg  <= full_addr + 24'd1;
              end
            end
          end
          ST_DUMMY: if (byte_stb) begin
            dummy_cnt_reg <= dummy_cnt_reg + 1'b1;
            if (dummy_cnt_reg == DCW'(DLAST)) begin
              state_reg <= ST_DATA;
              addr_reg  <= addr_reg + 24'd1;
            end
          end
          ST_DATA: if (byte_stb) addr_reg <= addr_reg + 24'd1;
          ST_ID:   if (byte_stb && id_cnt_reg != 2'd3) id_cnt_reg <= id_cnt_reg + 2'd1;
          default: ;
        endcase
      end
    end
  end

  // Image RAM: a read in the same cycle as a write to that word sees old data.
  always_ff @(posedge clk) begin
    if (mem_wr_ena) mem[mem_wr_addr] <= mem_wr_data;
    if (ram_ld)     rd_word_reg <= mem[rd_addr[MEM_AW+1:2]];
  end

  // Load pipeline; flushed by CS inactive so an aborted read sends nothing.
  always_ff @(posedge clk) begin
    if (rst || cs_high) begin
      ld_ram_reg   <= 1'b0;
      ld_const_reg <= 1'b0;
      const_reg    <= 8'h00;
      lane_reg     <= 2'd0;
    end else begin
      ld_ram_reg   <= ram_ld;
      ld_const_reg <= const_ld;
      const_reg    <= const_byte;
      lane_reg     <= rd_addr[1:0];
    end
  end

  assign tx_load = ld_ram_reg | ld_const_reg;
  assign tx_byte = ld_ram_reg ? lane_byte(rd_word_reg, lane_reg) : const_reg;

endmodule

// File: tb/tb_spi_flash_emu.sv
`timescale 1ns/1ps
module tb_spi_flash_emu;
  import spi_flash_emu_pkg::*;

  localparam int H = 8;  // SCK half period in clk cycles

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, spi_clk, mosi;
  logic [1:0]  cs_n, wr_ena;
  logic [31:0] wr_data;
  logic [9:0]  wr_addr;
  logic        miso0, miso1;
  logic [7:0]  mon_cmd0, mon_cmd1;
  logic        mon_cmd_stb0, mon_cmd_stb1, mon_addr_stb0, mon_addr_stb1;
  logic [23:0] mon_addr0, mon_addr1;

  spi_flash_emu #(.MEM_AW(10), .JEDEC_ID(24'hEF4018), .DUMMY_BYTES(1)) dut0 (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs_n(cs_n[0]), .spi_mosi(mosi),
    .spi_miso(miso0), .mem_wr_data(wr_data), .mem_wr_addr(wr_addr), .mem_wr_ena(wr_ena[0]),
    .mon_cmd(mon_cmd0), .mon_cmd_stb(mon_cmd_stb0), .mon_addr(mon_addr0), .mon_addr_stb(mon_addr_stb0)
  );

  spi_flash_emu #(.MEM_AW(2), .JEDEC_ID(24'hEF4018), .DUMMY_BYTES(2)) dut1 (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs_n(cs_n[1]), .spi_mosi(mosi),
    .spi_miso(miso1), .mem_wr_data(wr_data), .mem_wr_addr(wr_addr[1:0]), .mem_wr_ena(wr_ena[1]),
    .mon_cmd(mon_cmd1), .mon_cmd_stb(mon_cmd_stb1), .mon_addr(mon_addr1), .mon_addr_stb(mon_addr_stb1)
  );

  // Reference image: plain byte arrays, byte address = 4*word + lane.
  logic [7:0] model0 [0:4095];
  logic [7:0] model1 [0:15];
  logic [7:0] tx_buf [0:31];
  logic [7:0] rx_buf [0:31];
  int cmd_stb_n [2];
  int addr_stb_n [2];
  int n_pass = 0, n_total = 0, n_fail = 0;
  logic [2:0] st_after;
  logic       miso_after;

  always @(negedge clk) begin
    if (mon_cmd_stb0)  cmd_stb_n[0]  <= cmd_stb_n[0] + 1;
    if (mon_cmd_stb1)  cmd_stb_n[1]  <= cmd_stb_n[1] + 1;
    if (mon_addr_stb0) addr_stb_n[0] <= addr_stb_n[0] + 1;
    if (mon_addr_stb1) addr_stb_n[1] <= addr_stb_n[1] + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_total++;
    assert (obs === req) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, req);
    end
  endtask

  function automatic logic [7:0] model_byte(input int sel, input int a);
    return (sel == 0) ? model0[a % 4096] : model1[a % 16];
  endfunction

  task automatic host_write(input int sel, input int w, input logic [31:0] d);
    @(negedge clk);
    wr_addr = w[9:0];
    wr_data = d;
    wr_ena = 2'b00;
    wr_ena[sel] = 1'b1;
    @(negedge clk);
    wr_ena = 2'b00;
    for (int k = 0; k < 4; k++) begin
      if (sel == 0) model0[4*w + k] = d[8*k +: 8];
      else          model1[(4*w + k) % 16] = d[8*k +: 8];
    end
  endtask

  // Mode-0 controller: MOSI changes while SCK is low, MISO sampled at the rise.
  // cut_bits > 0 aborts the transfer after that many bits.
  task automatic xfer(input int sel, input int nbytes, input int cut_bits);
    int total;
    total = (cut_bits > 0) ? cut_bits : nbytes * 8;
    for (int i = 0; i < 32; i++) rx_buf[i] = 8'h00;
    @(negedge clk);
    cs_n[sel] = 1'b0;
    repeat (H) @(negedge clk);
    for (int b = 0; b < total; b++) begin
      mosi = tx_buf[b/8][7 - b%8];
      repeat (H) @(negedge clk);
      rx_buf[b/8][7 - b%8] = (sel == 0) ? miso0 : miso1;
      spi_clk = 1'b1;
      repeat (H) @(negedge clk);
      spi_clk = 1'b0;
    end
    repeat (H) @(negedge clk);
    cs_n[sel] = 1'b1;
    mosi = 1'b0;
    repeat (3) @(negedge clk);
    st_after   = (sel == 0) ? dut0.state_reg : dut1.state_reg;
    miso_after = (sel == 0) ? miso0 : miso1;
    repeat (2*H) @(negedge clk);
  endtask

  task automatic run_read(input int sel, input logic [7:0] op, input logic [23:0] a, input int len);
    int nd, pre, sa, sc;
    nd = (op == CMD_FAST_READ) ? ((sel == 0) ? 1 : 2) : 0;
    pre = 4 + nd;
    tx_buf[0] = op; tx_buf[1] = a[23:16]; tx_buf[2] = a[15:8]; tx_buf[3] = a[7:0];
    for (int i = 4; i < 32; i++) tx_buf[i] = 8'($urandom());
    sa = addr_stb_n[sel];
    sc = cmd_stb_n[sel];
    xfer(sel, pre + len, 0);
    $display("read dut%0d op=%02h addr=%06h len=%0d", sel, op, a, len);
    for (int i = 0; i < nd; i++) chk($sformatf("dummy%0d", i), 32'(rx_buf[4+i]), 32'h0);
    for (int i = 0; i < len; i++)
      chk($sformatf("rd_byte%0d", i), 32'(rx_buf[pre+i]), 32'(model_byte(sel, int'(a) + i)));
    chk("mon_addr", 32'((sel == 0) ? mon_addr0 : mon_addr1), 32'(a));
    chk("addr_stb_count", 32'(addr_stb_n[sel] - sa), 32'd1);
    chk("mon_cmd", 32'((sel == 0) ? mon_cmd0 : mon_cmd1), 32'(op));
    chk("cmd_stb_count", 32'(cmd_stb_n[sel] - sc), 32'd1);
  endtask

  initial begin
    logic [31:0] old_w, new_w;
    logic [7:0]  ob, nb;
    bit          seen_new;
    int sa;

    rst = 1'b1; spi_clk = 1'b0; mosi = 1'b0; cs_n = 2'b11;
    wr_ena = 2'b00; wr_data = 32'h0; wr_addr = 10'h0;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_miso",     32'(miso0), 32'h0);
    chk("rst_mon_cmd",  32'(mon_cmd0), 32'h0);
    chk("rst_mon_addr", 32'(mon_addr0), 32'h0);
    chk("rst_strobes",  32'({mon_cmd_stb0, mon_addr_stb0}), 32'h0);
    chk("rst_state",    32'(dut0.state_reg), 32'(ST_IDLE));
    chk("rst_state1",   32'(dut1.state_reg), 32'(ST_IDLE));

    // Images
    host_write(0, 0, 32'h44332211);
    for (int w = 1; w < 1024; w++) host_write(0, w, $urandom());
    for (int w = 0; w < 4; w++) host_write(1, w, $urandom());

    // 03h from address 0
    run_read(0, CMD_READ, 24'h000000, 4);
    chk("read0_b0", 32'(rx_buf[4]), 32'h11);
    chk("read0_b1", 32'(rx_buf[5]), 32'h22);
    chk("read0_b2", 32'(rx_buf[6]), 32'h33);
    chk("read0_b3", 32'(rx_buf[7]), 32'h44);

    // 0Bh with one dummy byte
    run_read(0, CMD_FAST_READ, 24'h000002, 2);
    chk("fast_b0", 32'(rx_buf[5]), 32'h33);
    chk("fast_b1", 32'(rx_buf[6]), 32'h44);

    // 0Bh with two dummy bytes, small image
    run_read(1, CMD_FAST_READ, 24'h000005, 3);

    // JEDEC ID
    tx_buf[0] = CMD_RDID;
    for (int i = 1; i < 5; i++) tx_buf[i] = 8'($urandom());
    sa = cmd_stb_n[0];
    xfer(0, 5, 0);
    $display("rdid dut0 -> %02h %02h %02h %02h", rx_buf[1], rx_buf[2], rx_buf[3], rx_buf[4]);
    chk("id_b0", 32'(rx_buf[1]), 32'hEF);
    chk("id_b1", 32'(rx_buf[2]), 32'h40);
    chk("id_b2", 32'(rx_buf[3]), 32'h18);
    chk("id_b3", 32'(rx_buf[4]), 32'h00);
    chk("id_mon_cmd", 32'(mon_cmd0), 32'h9F);
    chk("id_cmd_stb_count", 32'(cmd_stb_n[0] - sa), 32'd1);

    // Wrap at the end of a 16-byte image
    run_read(1, CMD_READ, 24'h00000F, 2);
    chk("wrap_b0", 32'(rx_buf[4]), 32'(model1[15]));
    chk("wrap_b1", 32'(rx_buf[5]), 32'(model1[0]));

    // Abort 5 bits into an address byte, then status read
    tx_buf[0] = CMD_READ; tx_buf[1] = 8'h12; tx_buf[2] = 8'h34;
    sa = addr_stb_n[0];
    xfer(0, 3, 21);
    $display("abort dut0 after 21 bits");
    chk("abort_idle", 32'(st_after), 32'(ST_IDLE));
    chk("abort_miso", 32'(miso_after), 32'h0);
    tx_buf[0] = CMD_RDSR; tx_buf[1] = 8'hA5;
    xfer(0, 2, 0);
    $display("rdsr dut0 -> %02h", rx_buf[1]);
    chk("status_byte", 32'(rx_buf[1]), 32'h00);
    chk("abort_no_addr_stb", 32'(addr_stb_n[0] - sa), 32'd0);
    chk("abort_mon_addr", 32'(mon_addr0), 32'h000002);
    chk("status_mon_cmd", 32'(mon_cmd0), 32'h05);
    chk("status_idle", 32'(st_after), 32'(ST_IDLE));

    // Host write to word 1 while word 1 is being read out
    old_w = {model0[7], model0[6], model0[5], model0[4]};
    new_w = ~old_w;
    tx_buf[0] = CMD_READ; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00; tx_buf[3] = 8'h04;
    for (int i = 4; i < 12; i++) tx_buf[i] = 8'h00;
    fork
      xfer(0, 12, 0);
      begin
        repeat (4*16*H + 6*H) @(negedge clk);
        host_write(0, 1, new_w);
      end
    join
    $display("read during write dut0 word1 old=%08h new=%08h", old_w, new_w);
    seen_new = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ob = old_w[8*i +: 8];
      nb = new_w[8*i +: 8];
      if (rx_buf[4+i] === nb) seen_new = 1'b1;
      chk($sformatf("rw_byte%0d_old_or_new", i),
          32'((rx_buf[4+i] === nb) || (rx_buf[4+i] === ob && !seen_new)), 32'd1);
    end
    for (int i = 4; i < 8; i++) chk($sformatf("rw_word2_b%0d", i), 32'(rx_buf[4+i]), 32'(model0[4+i]));
    run_read(0, CMD_READ, 24'h000004, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("rw_new_b%0d", i), 32'(rx_buf[4+i]), 32'(new_w[8*i +: 8]));

    // Randomised reads against the byte model
    for (int t = 0; t < 6; t++) begin
      int sel;
      sel = $urandom_range(0, 1);
      run_read(sel, ($urandom_range(0, 1) != 0) ? CMD_FAST_READ : CMD_READ,
               24'($urandom()), $urandom_range(1, 6));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
